ed_gen: RTL and testbench
=========================

// Module: ed_gen
// PURPOSE
// - Edge generator: the transmit-side counterpart of ed_det. Converts 1-cycle event strobes into
//   level transitions/pulses that a downstream ed_det of the same TYPE recovers one-for-one.
// - Each transition is held >= HOLD cycles. Events that arrive while busy queue in a saturating
//   pending counter. Used at block boundaries to drive slow/registered strobe links.
// PARAMETERS
// - TYPE            "ed"   "ed": each event toggles out; "ris": high pulse; "fal": low pulse
// - HOLD            4      cycles each level is held, min 1
// - PEND_W          4      pending-counter width; capacity 2**PEND_W-1 events
// - OUT_RESET_VALUE 1'b0   out during reset ("ed" only; "ris" idles 0, "fal" idles 1)
// PORTS
// - clk       in   1       clock
// - reset     in   1       asynchronous, active-high reset
// - in        in   1       event strobe, sampled each posedge; each high cycle = one event
// - out       out  1       generated level, registered
// - busy      out  1       1 while a transition/pulse is being held or events are pending
// - ovf       out  1       1-cycle pulse: event dropped because pending counter full
// - pend_cnt  out  PEND_W  events queued, not yet started
// BEHAVIOUR
// - Reset (async assert, sync release): out = idle level (OUT_RESET_VALUE for "ed", 0 "ris",
//   1 "fal"); busy=0, ovf=0, pend_cnt=0; state IDLE; timer=0. Reset mid-pulse aborts the pulse.
// - FSM states: IDLE, ACT (active level held), GAP (idle level held; "ris"/"fal" only).
// - IDLE: event available (in=1 or pend_cnt>0) -> out flips at that same edge; timer=HOLD-1;
//   next state ACT. With in=1 and pend_cnt=0: 1-cycle latency from in edge to out.
//   With pend_cnt>0: the pending event is consumed first and a simultaneous in is queued.
// - ACT, timer>0: timer-1. ACT, timer==0:
//   "ed": go to IDLE, but if an event is available, toggle again at this edge (back-to-back,
//   spacing exactly HOLD); "ris"/"fal": out returns to idle level, timer=HOLD-1, go to GAP.
// - GAP, timer>0: timer-1. GAP, timer==0: same as IDLE (immediate start if an event is
//   available), so pulse period = 2*HOLD.
// - Pending counter, per edge: +1 if in=1 and the event is not started at this edge;
//   -1 if a queued event starts; both -> unchanged. At 2**PEND_W-1 with only +1 requested:
//   hold the value, ovf=1 for that cycle.
// - busy = (state!=IDLE) | (pend_cnt!=0), registered alongside state.
// - Event conservation: toggles ("ed") or pulses ("ris"/"fal") emitted = accepted events;
//   an ed_det of the same TYPE on out gives one strobe per accepted event.
// - Timer width = clog2(HOLD), min 1. HOLD=1: "ed" can toggle every cycle.
// STRUCTURE
// - Shared include ed_defs.vh: TYPE string constants and idle-level function, shared with
//   ed_det. Add localparams for FSM state encodings.
// - One sub-module: ed_gen_timer (load/dec/zero down-counter, width from HOLD).
// - FSM, pending counter and out register in ed_gen.
// TESTING
// - Reset: drive reset=1 at t=3ns (async, mid-cycle) -> out=idle, busy=0 immediately,
//   before the next posedge.
// - "ed", HOLD=4, single in pulse at edge 10 -> out toggles at edge 10, busy low at edge 14,
//   pend_cnt stays 0.
// - "ed", HOLD=4, in high edges 10..12 -> toggles at 10,14,18; pend_cnt 1,2,1,0;
//   ed_det "ed" on out gives 3 strobes.
// - "ris", HOLD=3, 2 events back-to-back -> out high 10-12, low 13-15, high 16-18; period 6.
// - Overflow: PEND_W=2, HOLD=8, in high 6 cycles -> pend_cnt saturates at 3,
//   ovf pulses on 2 cycles, exactly 4 pulses emitted.
// - Reset asserted mid-ACT with pend_cnt=2 -> out idle, pend_cnt=0; after release no further
//   transitions occur.

Source files
------------

// File: rtl/ed_gen_pkg.sv
// ed_gen_pkg: shared types and helpers for the edge generator.
//   gen_state_e  - FSM state encoding (idle / active level held / idle level held)
//   timer_width  - width of the hold timer for a given HOLD (never below 1 bit)
//   idle_level   - level the output rests at between events, per edge type
package ed_gen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAct  = 2'd1,
        StGap  = 2'd2
    } gen_state_e;

    // Hold timer counts HOLD-1 down to 0; HOLD=1 still needs a 1-bit register.
    function automatic int unsigned timer_width(input int unsigned hold);
        int unsigned w;
        w = $clog2(hold);
        return (w < 1) ? 1 : w;
    endfunction

    // "ris" rests low, "fal" rests high, "ed" rests at its configured reset value.
    function automatic logic idle_level(input logic is_ris, input logic is_fal,
                                        input logic reset_val);
        if (is_ris) begin
            return 1'b0;
        end
        if (is_fal) begin
            return 1'b1;
        end
        return reset_val;
    endfunction

endpackage

// File: rtl/ed_gen_timer.sv
// ed_gen_timer: load/decrement down-counter timing how long a level is held.
//   clk_i    clock
//   reset_i  asynchronous active-high reset (count cleared)
//   load_i   load HOLD-1 (has priority over decrement)
//   dec_i    decrement by one; saturates at zero
//   zero_o   count is zero
module ed_gen_timer
    import ed_gen_pkg::*;
#(
    parameter int unsigned HOLD = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned TW = timer_width(HOLD);
    localparam logic [TW-1:0] LoadVal = TW'(HOLD - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LoadVal;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ed_gen.sv
// ed_gen: edge generator. Turns 1-cycle event strobes into toggles ("ed") or held pulses
// ("ris" high pulse, "fal" low pulse) that an edge detector of the same type recovers
// one-for-one. Every level is held HOLD cycles; events arriving while busy are queued in a
// saturating pending counter.
//   clk       clock
//   reset     asynchronous active-high reset
//   in        event strobe; every high cycle is one event
//   out       generated level (registered)
//   busy      a level is being held or events are pending (registered)
//   ovf       1-cycle pulse: an event was dropped because the pending counter was full
//   pend_cnt  events queued but not yet started
module ed_gen
    import ed_gen_pkg::*;
#(
    parameter string       TYPE            = "ed",
    parameter int unsigned HOLD            = 4,     // >= 1
    parameter int unsigned PEND_W          = 4,
    parameter logic        OUT_RESET_VALUE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    output logic              out,
    output logic              busy,
    output logic              ovf,
    output logic [PEND_W-1:0] pend_cnt
);

    localparam bit   IsRis   = (TYPE == "ris");
    localparam bit   IsFal   = (TYPE == "fal");
    localparam bit   IsEd    = !IsRis && !IsFal;
    localparam logic IdleLvl = idle_level(IsRis, IsFal, OUT_RESET_VALUE);

    gen_state_e        state_q, state_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;
    logic [PEND_W-1:0] pend_q, pend_d;

    logic tmr_load, tmr_dec, tmr_zero;
    logic pend_any, pend_full, avail, start, pend_inc, pend_dec;

    ed_gen_timer #(
        .HOLD (HOLD)
    ) u_timer (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (tmr_load),
        .dec_i   (tmr_dec),
        .zero_o  (tmr_zero)
    );

    always_comb begin
        pend_any  = (pend_q != '0);
        pend_full = &pend_q;
        avail     = in | pend_any;

        state_d  = state_q;
        out_d    = out_q;
        start    = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                start = avail;
            end
            StAct: begin
                if (tmr_zero) begin
                    if (IsEd) begin
                        // Back-to-back toggle keeps the spacing at exactly HOLD.
                        start = avail;
                        if (!avail) begin
                            state_d = StIdle;
                        end
                    end else begin
                        out_d    = IdleLvl;
                        tmr_load = 1'b1;
                        state_d  = StGap;
                    end
                end
            end
            StGap: begin
                if (tmr_zero) begin
                    start = avail;
                    if (!avail) begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start) begin
            state_d  = StAct;
            tmr_load = 1'b1;
            out_d    = IsEd ? ~out_q : ~IdleLvl;
        end

        // A queued event always starts before a fresh strobe; the strobe then takes its slot.
        pend_dec = start & pend_any;
        pend_inc = in & ~(start & ~pend_any);

        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (pend_inc && !pend_dec) begin
            if (pend_full) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (pend_dec && !pend_inc) begin
            pend_d = pend_q - 1'b1;
        end

        busy_d = (state_d != StIdle) | (pend_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            out_q   <= IdleLvl;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            pend_q  <= pend_d;
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;
    assign pend_cnt = pend_q;

endmodule

// File: tb/tb_ed_gen.sv
// Bench for ed_gen: four instances (ed/H4, ris/H3, fal/H8 with 2-bit queue, ed/H1 reset-high)
// checked every cycle against a timing-based model, plus directed literal scenarios.
module tb_ed_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_s   [4];
    logic out_s  [4];
    logic busy_s [4];
    logic ovf_s  [4];
    logic [3:0] pend_a;
    logic [3:0] pend_b;
    logic [1:0] pend_c;
    logic [2:0] pend_d;

    int errors = 0;
    int checks = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    ed_gen #(.TYPE("ed"),  .HOLD(4), .PEND_W(4), .OUT_RESET_VALUE(1'b0)) u_a (
        .clk(clk), .reset(rst), .in(in_s[0]), .out(out_s[0]), .busy(busy_s[0]),
        .ovf(ovf_s[0]), .pend_cnt(pend_a));
    ed_gen #(.TYPE("ris"), .HOLD(3), .PEND_W(4), .OUT_RESET_VALUE(1'b0)) u_b (
        .clk(clk), .reset(rst), .in(in_s[1]), .out(out_s[1]), .busy(busy_s[1]),
        .ovf(ovf_s[1]), .pend_cnt(pend_b));
    ed_gen #(.TYPE("fal"), .HOLD(8), .PEND_W(2), .OUT_RESET_VALUE(1'b0)) u_c (
        .clk(clk), .reset(rst), .in(in_s[2]), .out(out_s[2]), .busy(busy_s[2]),
        .ovf(ovf_s[2]), .pend_cnt(pend_c));
    ed_gen #(.TYPE("ed"),  .HOLD(1), .PEND_W(3), .OUT_RESET_VALUE(1'b1)) u_d (
        .clk(clk), .reset(rst), .in(in_s[3]), .out(out_s[3]), .busy(busy_s[3]),
        .ovf(ovf_s[3]), .pend_cnt(pend_d));

    // Per-instance configuration as the model sees it.
    localparam int M_HOLD [4] = '{4, 3, 8, 1};
    localparam int M_ED   [4] = '{1, 0, 0, 1};
    localparam int M_CAP  [4] = '{15, 15, 3, 7};
    localparam int M_IDLE [4] = '{0, 0, 1, 1};

    // Model: an event may start once a full period has elapsed since the last start.
    int m_n;
    int m_last [4];
    int m_pend [4];
    int m_out  [4];
    int m_ovf  [4];
    int m_busy [4];

    function automatic int pend_of(input int i);
        case (i)
            0:       return int'(pend_a);
            1:       return int'(pend_b);
            2:       return int'(pend_c);
            default: return int'(pend_d);
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n = 0;
        for (int i = 0; i < 4; i++) begin
            m_last[i] = -1000;
            m_pend[i] = 0;
            m_out[i]  = M_IDLE[i];
            m_ovf[i]  = 0;
            m_busy[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int ev);
        int period;
        period    = M_ED[i] != 0 ? M_HOLD[i] : 2 * M_HOLD[i];
        m_ovf[i]  = 0;
        if (M_ED[i] == 0 && (m_n - m_last[i]) == M_HOLD[i]) m_out[i] = M_IDLE[i];
        if ((m_n - m_last[i]) >= period && (ev != 0 || m_pend[i] > 0)) begin
            m_last[i] = m_n;
            if (m_pend[i] > 0) m_pend[i] = m_pend[i] - 1 + ev;
            m_out[i] = M_ED[i] != 0 ? 1 - m_out[i] : 1 - M_IDLE[i];
        end else if (ev != 0) begin
            if (m_pend[i] == M_CAP[i]) m_ovf[i] = 1;
            else m_pend[i] = m_pend[i] + 1;
        end
        m_busy[i] = ((m_n - m_last[i]) < period || m_pend[i] > 0) ? 1 : 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                m_n++;
                for (int i = 0; i < 4; i++) model_step(i, int'(in_s[i]));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("out[%0d]", i),  int'(out_s[i]),  m_out[i]);
                    chk($sformatf("busy[%0d]", i), int'(busy_s[i]), m_busy[i]);
                    chk($sformatf("ovf[%0d]", i),  int'(ovf_s[i]),  m_ovf[i]);
                    chk($sformatf("pend[%0d]", i), pend_of(i),      m_pend[i]);
                end
            end
        end
    end

    int exp_pend_a [10] = '{0, 1, 2, 2, 1, 1, 1, 1, 0, 0};
    int exp_out_a  [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    int exp_out_b  [14] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    int exp_busy_b [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    int dens_tab   [6]  = '{10, 30, 60, 90, 25, 100};

    initial begin
        int novf, nfall, pmax, ntog, prev;
        for (int i = 0; i < 4; i++) in_s[i] = 1'b0;

        // Asynchronous reset assertion mid-cycle.
        #3;
        rst   = 1'b1;
        armed = 1'b1;
        #1;
        chk("rst_out_a", int'(out_s[0]), 0);
        chk("rst_out_b", int'(out_s[1]), 0);
        chk("rst_out_c", int'(out_s[2]), 1);
        chk("rst_out_d", int'(out_s[3]), 1);
        chk("rst_busy_a", int'(busy_s[0]), 0);
        chk("rst_pend_c", int'(pend_c), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // "ed" HOLD=4: single event, busy drops HOLD edges after the toggle.
        @(negedge clk);
        in_s[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("a_single_out", int'(out_s[0]), 1);
        chk("a_single_busy0", int'(busy_s[0]), 1);
        chk("a_single_pend", int'(pend_a), 0);
        @(negedge clk);
        in_s[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1;
        chk("a_single_busy3", int'(busy_s[0]), 1);
        @(posedge clk);
        #1;
        chk("a_single_busy4", int'(busy_s[0]), 0);
        chk("a_single_hold", int'(out_s[0]), 1);

        // "ed" HOLD=4: three consecutive events, toggles HOLD apart.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_s[0] = (k < 3);
            @(posedge clk);
            #1;
            chk($sformatf("a_burst_pend%0d", k), int'(pend_a), exp_pend_a[k]);
            chk($sformatf("a_burst_out%0d", k), int'(out_s[0]), exp_out_a[k]);
        end

        // "ris" HOLD=3: two back-to-back events give a 6-cycle pulse period.
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            in_s[1] = (k < 2);
            @(posedge clk);
            #1;
            chk($sformatf("b_out%0d", k), int'(out_s[1]), exp_out_b[k]);
            chk($sformatf("b_busy%0d", k), int'(busy_s[1]), exp_busy_b[k]);
        end

        // "fal" HOLD=8, 2-bit queue: six events, two dropped, four pulses.
        novf  = 0;
        nfall = 0;
        pmax  = 0;
        prev  = int'(out_s[2]);
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            in_s[2] = (k < 6);
            @(posedge clk);
            #1;
            if (ovf_s[2]) novf++;
            if (prev == 1 && out_s[2] == 1'b0) nfall++;
            prev = int'(out_s[2]);
            if (int'(pend_c) > pmax) pmax = int'(pend_c);
            if (k == 5) chk("c_pend_sat", int'(pend_c), 3);
        end
        chk("c_ovf_count", novf, 2);
        chk("c_pulses", nfall, 4);
        chk("c_pend_max", pmax, 3);
        chk("c_busy_end", int'(busy_s[2]), 0);

        // Reset mid-ACT with two events queued aborts everything.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_s[0] = 1'b1;
            @(posedge clk);
        end
        #1;
        chk("a_pre_rst_pend", int'(pend_a), 2);
        chk("a_pre_rst_out", int'(out_s[0]), 1);
        #1;
        in_s[0] = 1'b0;
        rst     = 1'b1;
        #1;
        chk("a_rst_out", int'(out_s[0]), 0);
        chk("a_rst_pend", int'(pend_a), 0);
        chk("a_rst_busy", int'(busy_s[0]), 0);
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        ntog = 0;
        prev = int'(out_s[0]);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (int'(out_s[0]) != prev) ntog++;
            prev = int'(out_s[0]);
        end
        chk("a_post_rst_toggles", ntog, 0);

        // Randomized traffic with occasional mid-cycle resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            rst = ($urandom_range(599) == 0);
            for (int i = 0; i < 4; i++) begin
                in_s[i] = ($urandom_range(99) < dens_tab[c / 500]);
            end
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) in_s[i] = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_busy[%0d]", i), int'(busy_s[i]), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
